iomem_bus_ctrl: RTL and testbench
=================================

Name: iomem_bus_ctrl

Overview:
- Sequencing controller for the PicoSoC iomem bus.
- Decodes CPU iomem requests in the 0x03xx_xxxx window and routes each one to one of NUM_SLAVES peripheral ports (GPIO, timer, PWM, ...).
- Multiplexes ready/rdata back to the CPU through a registered FSM and guarantees one ready pulse per transaction.
- Answers decode misses and hung slaves with an error response, so each peripheral no longer drives iomem_ready/iomem_rdata itself.

Parameters:
- NUM_SLAVES, 4, number of slave ports; legal range 1..16.
- BASE_HI, 8'h03, required value of m_addr[31:24] for the block to claim a request.
- TIMEOUT_CYCLES, 255, maximum wait cycles in ACCESS before a forced error response; legal range 1..65535.
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on a decode or timeout error.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m_valid  in  1  CPU iomem_valid
- m_ready  out  1  CPU iomem_ready; one-cycle pulse
- m_wstrb  in  4  byte write strobes; 0 = read
- m_addr  in  32  byte address
- m_wdata  in  32  write data
- m_rdata  out  32  read data; valid while m_ready=1
- s_valid  out  NUM_SLAVES  one-hot slave select; registered
- s_wstrb  out  4  registered copy of m_wstrb
- s_addr  out  32  registered copy of m_addr
- s_wdata  out  32  registered copy of m_wdata
- s_ready  in  NUM_SLAVES  per-slave ready
- s_rdata  in  32*NUM_SLAVES  per-slave read data; slave i at bits [32*i+31:32*i]
- err_clr  in  1  clears err_flag
- err_flag  out  1  sticky error indicator
- err_addr  out  32  address of the most recent errored request
- err_count  out  8  saturating error counter

Behaviour:
- Reset (resetn=0 at a clk edge), values regardless of state:
  - state=IDLE; m_ready=0; m_rdata=0; s_valid=0; s_wstrb=0; s_addr=0; s_wdata=0.
  - err_flag=0; err_addr=0; err_count=0; wait counter=0.
- Hit: m_valid=1 and m_addr[31:24]==BASE_HI.
  - Slave index idx = m_addr[23:20].
  - Requests that are not hits are ignored: m_ready stays 0.
- IDLE, on hit with idx<NUM_SLAVES:
  - Latch wstrb/addr/wdata to s_*.
  - Next cycle s_valid[idx]=1; go to ACCESS; clear the wait counter.
- IDLE, on hit with idx>=NUM_SLAVES (decode error):
  - Go to RESP with m_rdata=ERR_DATA; log the error.
  - No s_valid is asserted.
- ACCESS:
  - s_valid[idx] is held; the wait counter increments each cycle.
  - When s_ready[idx]=1 at an edge: capture slave idx rdata into m_rdata, drop s_valid, go to RESP.
  - Ready from a non-selected slave is ignored.
  - When the counter reaches TIMEOUT_CYCLES with no ready: drop s_valid, m_rdata=ERR_DATA, log the error, go to RESP.
  - If s_ready[idx] arrives in the same cycle as the timeout, ready wins: normal completion, no error.
- RESP:
  - m_ready=1 for exactly one cycle, then go to IDLE.
  - On writes m_rdata is don't-care, but it still carries the captured value.
- Back-to-back requests:
  - IDLE never accepts in the cycle m_ready=1.
  - Earliest re-accept is the cycle after RESP.
- Latency: hit sampled at edge N gives s_valid=1 in cycle N+1. With s_ready in cycle N+1, m_ready=1 in cycle N+2. Minimum is 2 cycles; a decode error takes 1 cycle.
- m_valid dropping in ACCESS: the transaction runs to completion and m_ready still pulses once (the CPU never does this; the behaviour is defined for robustness).
- Error log:
  - err_flag set to 1; err_addr=request address; err_count+1, saturating at 255.
  - err_clr=1 clears err_flag only.
  - If err_clr and a new error coincide, the error wins and err_flag=1.
- Reset mid-ACCESS aborts: s_valid=0 on the next cycle and no m_ready is issued.

Optional Feature:
- Macro: IOMEM_BUS_TIMEOUT_EN.
- Defined: timeout counter and timeout error behave as described above.
- Undefined: no wait counter is built; ACCESS waits indefinitely for s_ready[idx]. Decode errors and the error log still function.

Test Plan:
- Read slave 0: m_addr=0x0300_0000, wstrb=0, s_ready[0]=1 with rdata 0x0000_00A5 in the first ACCESS cycle -> m_ready pulses 1 cycle in cycle N+2, m_rdata=0x0000_00A5, s_valid back to 0.
- Write slave 2: m_addr=0x0320_0004, wstrb=4'b0011, wdata=0x1234_5678, slave ready after 3 cycles -> s_valid=4'b0100 for 3 cycles, s_addr/s_wdata/s_wstrb match, single m_ready pulse.
- Decode miss: m_addr=0x0350_0000 with NUM_SLAVES=4 -> no s_valid, m_ready next cycle, m_rdata=0xDEAD_BEEF, err_flag=1, err_addr=0x0350_0000, err_count=1.
- Timeout: TIMEOUT_CYCLES=8, slave 1 never ready -> s_valid[1] high 8 cycles, then m_rdata=0xDEAD_BEEF, err_count increments. Ready in the timeout cycle instead -> normal data, no error. Without IOMEM_BUS_TIMEOUT_EN -> no response after 300 cycles.
- Non-hit and stray ready: m_addr=0x0200_0000 -> m_ready stays 0. s_ready[3]=1 during an access to slave 0 -> ignored.
- Reset and errors: resetn=0 mid-ACCESS -> all outputs reset values next cycle, no m_ready. 300 decode errors -> err_count=255. err_clr concurrent with an error -> err_flag=1.

Source files
------------

// File: rtl/iomem_bus_if.sv
// PicoSoC iomem bus bundle: CPU-side request/response plus the fanned-out peripheral port.
// master = the bus controller; slave = the CPU and peripherals facing it.
interface iomem_bus_if #(
  parameter int unsigned NUM_SLAVES = 4
);
  logic                         m_valid;
  logic                         m_ready;
  logic [3:0]                   m_wstrb;
  logic [31:0]                  m_addr;
  logic [31:0]                  m_wdata;
  logic [31:0]                  m_rdata;
  logic [NUM_SLAVES-1:0]        s_valid;
  logic [3:0]                   s_wstrb;
  logic [31:0]                  s_addr;
  logic [31:0]                  s_wdata;
  logic [NUM_SLAVES-1:0]        s_ready;
  logic [32*NUM_SLAVES-1:0]     s_rdata;

  modport master (
    input  m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );

  modport slave (
    output m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// Routes CPU iomem requests in the BASE_HI window to NUM_SLAVES peripherals and returns one
// registered ready pulse per transaction. Define IOMEM_BUS_TIMEOUT_EN to build the hung-slave timeout.
module iomem_bus_ctrl #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [7:0]  BASE_HI        = 8'h03,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic         clk,
  input  logic         resetn,
  iomem_bus_if.master  bus,
  input  logic         err_clr,
  output logic         err_flag,
  output logic [31:0]  err_addr,
  output logic [7:0]   err_count
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 16) begin : gen_bad_num_slaves
    $error("iomem_bus_ctrl: NUM_SLAVES must be 1..16");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : gen_bad_timeout
    $error("iomem_bus_ctrl: TIMEOUT_CYCLES must be 1..65535");
  end

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
  logic [3:0]            s_wstrb_q, s_wstrb_d;
  logic [31:0]           s_addr_q, s_addr_d;
  logic [31:0]           s_wdata_q, s_wdata_d;
  logic [31:0]           m_rdata_q, m_rdata_d;
  logic                  err_flag_q, err_flag_d;
  logic [31:0]           err_addr_q, err_addr_d;
  logic [7:0]            err_count_q, err_count_d;

  logic                  hit;
  logic [3:0]            idx;
  logic                  idx_ok;
  logic [NUM_SLAVES-1:0] idx_onehot;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;
  logic                  log_err;
  logic [31:0]           log_addr;

`ifdef IOMEM_BUS_TIMEOUT_EN
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
  logic        timeout;
  assign timeout = (wait_q == TimeoutLast);
`endif

  assign hit    = bus.m_valid && (bus.m_addr[31:24] == BASE_HI);
  assign idx    = bus.m_addr[23:20];
  assign idx_ok = 32'(idx) < NUM_SLAVES;
  // s_valid_q is one-hot on the selected slave, so masking drops stray readies.
  assign sel_ready = |(bus.s_ready & s_valid_q);

  always_comb begin
    idx_onehot = '0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      idx_onehot[i] = (idx == 4'(i));
      if (s_valid_q[i]) sel_rdata = bus.s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    s_valid_d   = s_valid_q;
    s_wstrb_d   = s_wstrb_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    m_rdata_d   = m_rdata_q;
    err_flag_d  = err_flag_q;
    err_addr_d  = err_addr_q;
    err_count_d = err_count_q;
    log_err     = 1'b0;
    log_addr    = '0;
`ifdef IOMEM_BUS_TIMEOUT_EN
    wait_d      = wait_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (hit) begin
          if (idx_ok) begin
            s_valid_d = idx_onehot;
            s_wstrb_d = bus.m_wstrb;
            s_addr_d  = bus.m_addr;
            s_wdata_d = bus.m_wdata;
            state_d   = StAccess;
`ifdef IOMEM_BUS_TIMEOUT_EN
            wait_d    = '0;
`endif
          end else begin
            m_rdata_d = ERR_DATA;
            log_err   = 1'b1;
            log_addr  = bus.m_addr;
            state_d   = StResp;
          end
        end
      end
      StAccess: begin
        // Ready takes priority over a timeout landing in the same cycle.
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          s_valid_d = '0;
          state_d   = StResp;
        end
`ifdef IOMEM_BUS_TIMEOUT_EN
        else if (timeout) begin
          m_rdata_d = ERR_DATA;
          s_valid_d = '0;
          log_err   = 1'b1;
          log_addr  = s_addr_q;
          state_d   = StResp;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (log_err) begin
      err_flag_d = 1'b1;
      err_addr_d = log_addr;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end else if (err_clr) begin
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      s_valid_q   <= '0;
      s_wstrb_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      m_rdata_q   <= '0;
      err_flag_q  <= 1'b0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_valid_q   <= s_valid_d;
      s_wstrb_q   <= s_wstrb_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      m_rdata_q   <= m_rdata_d;
      err_flag_q  <= err_flag_d;
      err_addr_q  <= err_addr_d;
      err_count_q <= err_count_d;
    end
  end

`ifdef IOMEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) wait_q <= '0;
    else         wait_q <= wait_d;
  end
`endif

  assign bus.m_ready = (state_q == StResp);
  assign bus.m_rdata = m_rdata_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_wstrb = s_wstrb_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;
  assign err_flag    = err_flag_q;
  assign err_addr    = err_addr_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_iomem_bus_ctrl.sv
// Bench for iomem_bus_ctrl: directed vector table, hand-written corner sequences and random
// transactions checked against a transaction-level model of the bus rules.
module tb_iomem_bus_ctrl;
  localparam int          NS  = 4;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        err_clr = 1'b0;
  logic        err_flag;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
  logic [31:0] sdata [NS];

  iomem_bus_if #(.NUM_SLAVES(NS)) bus ();

  assign bus.s_rdata = {sdata[3], sdata[2], sdata[1], sdata[0]};

  iomem_bus_ctrl #(
    .NUM_SLAVES    (NS),
    .BASE_HI       (8'h03),
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (ERR)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .err_clr  (err_clr),
    .err_flag (err_flag),
    .err_addr (err_addr),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // exp_cycles: -1 = ignored request, 0 = decode error, n>0 = s_valid held n cycles.
  // lat: ACCESS cycle in which the selected slave raises ready (0 = never).
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata_sel;
    logic [3:0]  exp_sv;
    int          exp_cycles;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic        m_flag = 1'b0;
  logic [31:0] m_eaddr = '0;
  int          m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t predict(input logic [31:0] addr, input logic [3:0] wstrb,
                                   input logic [31:0] wdata, input int lat,
                                   input logic [31:0] rd);
    vec_t v;
    v.addr = addr; v.wstrb = wstrb; v.wdata = wdata; v.lat = lat; v.rdata_sel = rd;
    v.exp_sv = '0; v.exp_rdata = '0; v.exp_err = 1'b0;
    if (addr[31:24] != 8'h03) begin
      v.exp_cycles = -1;
    end else if (int'(addr[23:20]) >= NS) begin
      v.exp_cycles = 0; v.exp_rdata = ERR; v.exp_err = 1'b1;
    end else begin
      v.exp_sv = 4'b0001 << addr[23:20];
      v.exp_cycles = lat; v.exp_rdata = rd;
`ifdef IOMEM_BUS_TIMEOUT_EN
      if (lat == 0 || lat > TMO) begin
        v.exp_cycles = TMO; v.exp_rdata = ERR; v.exp_err = 1'b1;
      end
`endif
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [3:0] idx;
    int         bad;
    idx = v.addr[23:20];
    if (int'(idx) < NS) sdata[idx[1:0]] = v.rdata_sel;
    bus.m_valid = 1'b1;
    bus.m_addr  = v.addr;
    bus.m_wstrb = v.wstrb;
    bus.m_wdata = v.wdata;
    tick();
    if (v.exp_cycles < 0) begin
      bad = 0;
      for (int k = 0; k < 6; k++) begin
        if (bus.m_ready !== 1'b0 || bus.s_valid !== 4'b0) bad++;
        tick();
      end
      chk("nohit_quiet", bad, 0);
      bus.m_valid = 1'b0;
    end else begin
      if (v.exp_cycles == 0) begin
        chk("dec_no_svalid", bus.s_valid, 4'b0);
      end else begin
        chk("s_valid_first", bus.s_valid, v.exp_sv);
        chk("s_addr", bus.s_addr, v.addr);
        chk("s_wdata", bus.s_wdata, v.wdata);
        chk("s_wstrb", bus.s_wstrb, v.wstrb);
        bad = 0;
        for (int k = 1; k <= v.exp_cycles; k++) begin
          if (bus.s_valid !== v.exp_sv || bus.m_ready !== 1'b0) bad++;
          // Non-selected slaves shout ready the whole time.
          bus.s_ready = (4'hF & ~v.exp_sv) | ((k == v.lat) ? v.exp_sv : 4'b0);
          tick();
        end
        bus.s_ready = '0;
        chk("access_hold", bad, 0);
        chk("s_valid_drop", bus.s_valid, 4'b0);
      end
      if (v.exp_err) begin
        m_flag = 1'b1;
        m_eaddr = v.addr;
        if (m_cnt < 255) m_cnt++;
      end
      chk("m_ready_pulse", bus.m_ready, 1'b1);
      chk("m_rdata", bus.m_rdata, v.exp_rdata);
      chk("err_flag", err_flag, m_flag);
      chk("err_addr", err_addr, m_eaddr);
      chk("err_count", err_count, 32'(m_cnt));
      bus.m_valid = 1'b0;
      tick();
      chk("m_ready_single", bus.m_ready, 1'b0);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_m_ready"}, bus.m_ready, 1'b0);
    chk({tag, "_m_rdata"}, bus.m_rdata, 32'h0);
    chk({tag, "_s_valid"}, bus.s_valid, 4'b0);
    chk({tag, "_s_wstrb"}, bus.s_wstrb, 4'b0);
    chk({tag, "_s_addr"}, bus.s_addr, 32'h0);
    chk({tag, "_s_wdata"}, bus.s_wdata, 32'h0);
    chk({tag, "_err_flag"}, err_flag, 1'b0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
    chk({tag, "_err_count"}, err_count, 32'h0);
  endtask

  vec_t tbl [6];

  initial begin
    tbl[0] = '{addr: 32'h0300_0000, wstrb: 4'h0, wdata: 32'h0, lat: 1,
               rdata_sel: 32'h0000_00A5, exp_sv: 4'b0001, exp_cycles: 1,
               exp_rdata: 32'h0000_00A5, exp_err: 1'b0};
    tbl[1] = '{addr: 32'h0320_0004, wstrb: 4'b0011, wdata: 32'h1234_5678, lat: 3,
               rdata_sel: 32'h5A5A_0002, exp_sv: 4'b0100, exp_cycles: 3,
               exp_rdata: 32'h5A5A_0002, exp_err: 1'b0};
    tbl[2] = '{addr: 32'h0350_0000, wstrb: 4'h0, wdata: 32'h0, lat: 1,
               rdata_sel: 32'h0, exp_sv: 4'b0000, exp_cycles: 0,
               exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b1};
    tbl[3] = '{addr: 32'h0200_0000, wstrb: 4'h0, wdata: 32'h0, lat: 1,
               rdata_sel: 32'h0, exp_sv: 4'b0000, exp_cycles: -1,
               exp_rdata: 32'h0, exp_err: 1'b0};
    tbl[4] = '{addr: 32'h0310_0010, wstrb: 4'h0, wdata: 32'h0, lat: 8,
               rdata_sel: 32'hC0DE_0001, exp_sv: 4'b0010, exp_cycles: 8,
               exp_rdata: 32'hC0DE_0001, exp_err: 1'b0};
    tbl[5] = '{addr: 32'h0330_00FC, wstrb: 4'b1111, wdata: 32'hA1B2_C3D4, lat: 2,
               rdata_sel: 32'h7777_3333, exp_sv: 4'b1000, exp_cycles: 2,
               exp_rdata: 32'h7777_3333, exp_err: 1'b0};

    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wstrb = '0; bus.m_wdata = '0;
    bus.s_ready = '0;
    for (int i = 0; i < NS; i++) sdata[i] = $urandom;

    tick();
    tick();
    check_reset_values("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

`ifdef IOMEM_BUS_TIMEOUT_EN
    run_vec('{addr: 32'h0310_0020, wstrb: 4'h0, wdata: 32'h0, lat: 0,
              rdata_sel: 32'h1111_2222, exp_sv: 4'b0010, exp_cycles: 8,
              exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b1});
`endif

    // err_clr alone clears only the flag.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_flag = 1'b0;
    chk("clr_flag", err_flag, 1'b0);
    chk("clr_keeps_count", err_count, 32'(m_cnt));
    chk("clr_keeps_addr", err_addr, m_eaddr);

    // err_clr coinciding with a new error: the error wins.
    err_clr = 1'b1;
    run_vec('{addr: 32'h03F0_0040, wstrb: 4'h0, wdata: 32'h0, lat: 1,
              rdata_sel: 32'h0, exp_sv: 4'b0000, exp_cycles: 0,
              exp_rdata: 32'hDEAD_BEEF, exp_err: 1'b1});
    err_clr = 1'b0;
    m_flag = 1'b0;
    chk("clr_after_resp", err_flag, 1'b0);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] a;
      int          lat;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[31:24] = 8'h03;
      a[23:20] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(4, 15))
                                             : 4'($urandom_range(0, 3));
`ifdef IOMEM_BUS_TIMEOUT_EN
      lat = $urandom_range(0, 12);
`else
      lat = $urandom_range(1, 12);
`endif
      for (int i = 0; i < NS; i++) sdata[i] = $urandom;
      run_vec(predict(a, 4'($urandom), $urandom, lat, $urandom));
    end

    // Hung slave, then reset in the middle of ACCESS.
    bus.m_valid = 1'b1;
    bus.m_addr  = 32'h0310_0008;
    bus.m_wstrb = 4'hF;
    bus.m_wdata = 32'hFACE_F00D;
    tick();
    chk("hung_s_valid", bus.s_valid, 4'b0010);
    tick();
`ifndef IOMEM_BUS_TIMEOUT_EN
    begin
      int resp = 0;
      int dropped = 0;
      for (int k = 0; k < 300; k++) begin
        if (bus.m_ready !== 1'b0) resp++;
        if (bus.s_valid !== 4'b0010) dropped++;
        tick();
      end
      chk("no_timeout_resp", resp, 0);
      chk("no_timeout_hold", dropped, 0);
    end
`endif
    resetn = 1'b0;
    bus.m_valid = 1'b0;
    tick();
    check_reset_values("midreset");
    m_flag = 1'b0; m_eaddr = '0; m_cnt = 0;
    resetn = 1'b1;
    tick();
    chk("post_reset_no_ready", bus.m_ready, 1'b0);

    for (int n = 0; n < 300; n++) begin
      run_vec(predict({8'h03, 4'($urandom_range(4, 15)), 20'($urandom)}, 4'h0, 32'h0, 1,
                      32'h0));
    end
    chk("err_count_sat", err_count, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
